// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap/mret sequencer: serialises mepc/mcause/mtval/mstatus updates
// onto the single csrfile write port and issues the fetch redirect.
module csr_trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wb_csr_we_i,
  input  logic [11:0]     wb_csr_waddr_i,
  input  logic [XLEN-1:0] wb_csr_wdata_i,
  input  logic            exc_valid_i,
  input  logic [3:0]      exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic            mret_i,
  input  logic            irq_ext_i,
  input  logic            irq_timer_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            csr_we_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            wb_stall_o,
  output logic            flush_o,
  output logic            busy_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_MEPC    = 3'd1,
    W_MCAUSE  = 3'd2,
    W_MTVAL   = 3'd3,
    W_MSTATUS = 3'd4,
    MRET_ST   = 3'd5,
    REDIRECT  = 3'd6
  } state_t;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  localparam logic [XLEN-1:0] CAUSE_EXT   = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
  localparam logic [XLEN-1:0] CAUSE_TIMER = {1'b1, {(XLEN-5){1'b0}}, 4'h7};

  state_t          state_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] cause_r;
  logic [XLEN-1:0] tval_r;
  logic [XLEN-1:0] mstatus_r;
  logic            irq_r;
  logic [XLEN-1:0] redirect_pc_r;

  logic            idle_s;
  logic            ext_ok_s;
  logic            timer_ok_s;
  logic            trigger_s;
  logic [XLEN-1:0] mstatus_eff_s;
  logic            unused_mie_s;

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r        = m;
    r[7]     = m[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Trap return: MIE <= MPIE, MPIE <= 1, MPP stays M.
  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r        = m;
    r[3]     = m[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] trap_vector(input logic [XLEN-1:0] tvec,
                                                  input logic            irq,
                                                  input logic [3:0]      code);
    logic [XLEN-1:0] base;
    base = {tvec[XLEN-1:2], 2'b00};
    if (irq && (tvec[1:0] == 2'b01)) begin
      return base + {{(XLEN-6){1'b0}}, code, 2'b00};
    end else begin
      return base;
    end
  endfunction

  assign idle_s       = (state_r == IDLE);
  assign ext_ok_s     = mstatus_i[3] & mie_i[11] & irq_ext_i;
  assign timer_ok_s   = mstatus_i[3] & mie_i[7] & irq_timer_i;
  assign trigger_s    = exc_valid_i | mret_i | ext_ok_s | timer_ok_s;
  assign unused_mie_s = ^{mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:0]};

  // A writeback update of mstatus in the trigger cycle must not be lost under the trap.
  assign mstatus_eff_s = (wb_csr_we_i && (wb_csr_waddr_i == ADDR_MSTATUS)) ?
                         wb_csr_wdata_i : mstatus_i;

  // Sequencer state and trap-context latches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= IDLE;
      pc_r          <= '0;
      cause_r       <= '0;
      tval_r        <= '0;
      mstatus_r     <= '0;
      irq_r         <= 1'b0;
      redirect_pc_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (exc_valid_i) begin
            pc_r      <= {exc_pc_i[XLEN-1:2], 2'b00};
            cause_r   <= {{(XLEN-4){1'b0}}, exc_cause_i};
            tval_r    <= exc_tval_i;
            mstatus_r <= mstatus_eff_s;
            irq_r     <= 1'b0;
            state_r   <= W_MEPC;
          end else if (mret_i) begin
            mstatus_r <= mstatus_eff_s;
            state_r   <= MRET_ST;
          end else if (ext_ok_s || timer_ok_s) begin
            pc_r      <= {exc_pc_i[XLEN-1:2], 2'b00};
            cause_r   <= ext_ok_s ? CAUSE_EXT : CAUSE_TIMER;
            tval_r    <= '0;
            mstatus_r <= mstatus_eff_s;
            irq_r     <= 1'b1;
            state_r   <= W_MEPC;
          end else begin
            state_r   <= IDLE;
          end
        end
        W_MEPC:    state_r <= W_MCAUSE;
        W_MCAUSE:  state_r <= W_MTVAL;
        W_MTVAL:   state_r <= W_MSTATUS;
        W_MSTATUS: begin
          redirect_pc_r <= trap_vector(mtvec_i, irq_r, cause_r[3:0]);
          state_r       <= REDIRECT;
        end
        MRET_ST: begin
          redirect_pc_r <= mepc_i;
          state_r       <= REDIRECT;
        end
        REDIRECT: begin
          redirect_pc_r <= '0;
          state_r       <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Write-port arbitration: writeback owns the port only while idle.
  always_comb begin
    csr_we_o    = 1'b0;
    csr_waddr_o = 12'h000;
    csr_wdata_o = '0;
    case (state_r)
      IDLE: begin
        csr_we_o    = wb_csr_we_i & ~rst_i;
        csr_waddr_o = wb_csr_waddr_i;
        csr_wdata_o = wb_csr_wdata_i;
      end
      W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MEPC;
        csr_wdata_o = pc_r;
      end
      W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MCAUSE;
        csr_wdata_o = cause_r;
      end
      W_MTVAL: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MTVAL;
        csr_wdata_o = tval_r;
      end
      W_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = trap_mstatus(mstatus_r);
      end
      MRET_ST: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = mret_mstatus(mstatus_r);
      end
      default: begin
        csr_we_o    = 1'b0;
        csr_waddr_o = 12'h000;
        csr_wdata_o = '0;
      end
    endcase
  end

  // Status and redirect outputs decoded from the state register.
  always_comb begin
    busy_o           = ~idle_s;
    wb_stall_o       = wb_csr_we_i & ~idle_s;
    redirect_valid_o = (state_r == REDIRECT);
    redirect_pc_o    = redirect_pc_r;
    if (idle_s) begin
      flush_o = trigger_s & ~rst_i;
    end else begin
      flush_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Randomised + directed bench for csr_trap_ctrl; a transaction-level model
// predicts the per-cycle write/redirect sequence that each trigger must produce.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [11:0] wb_waddr;
  logic [31:0] wb_wdata;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval;
  logic        mret, irq_ext, irq_timer;
  logic [31:0] mstatus, mie, mtvec, mepc;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        wb_stall, flush, busy, redirect_valid;
  logic [31:0] redirect_pc;

  int total = 0;
  int bad   = 0;

  csr_trap_ctrl #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_csr_we_i(wb_we), .wb_csr_waddr_i(wb_waddr), .wb_csr_wdata_i(wb_wdata),
    .exc_valid_i(exc_valid), .exc_cause_i(exc_cause), .exc_pc_i(exc_pc), .exc_tval_i(exc_tval),
    .mret_i(mret), .irq_ext_i(irq_ext), .irq_timer_i(irq_timer),
    .mstatus_i(mstatus), .mie_i(mie), .mtvec_i(mtvec), .mepc_i(mepc),
    .csr_we_o(csr_we), .csr_waddr_o(csr_waddr), .csr_wdata_o(csr_wdata),
    .wb_stall_o(wb_stall), .flush_o(flush), .busy_o(busy),
    .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One expected busy cycle of the controller.
  typedef struct {
    bit        we;
    bit [11:0] a;
    bit [31:0] d;
    bit        rv;
    bit [31:0] rpc;
  } ent_t;

  ent_t q[$];

  function automatic ent_t mk(bit we, bit [11:0] a, bit [31:0] d, bit rv, bit [31:0] rpc);
    ent_t e;
    e.we = we; e.a = a; e.d = d; e.rv = rv; e.rpc = rpc;
    return e;
  endfunction

  function automatic void push_trap(bit irq, bit [31:0] cause, bit [31:0] pc,
                                    bit [31:0] tval, bit [31:0] mst);
    bit [31:0] newst, vec;
    newst = (mst & ~32'h0000_1888) | (mst[3] ? 32'h80 : 32'h0) | 32'h1800;
    vec = mtvec & ~32'h3;
    if (irq && (mtvec[1:0] == 2'b01)) vec = vec + 4 * (cause & 32'hF);
    q.push_back(mk(1'b1, 12'h341, pc & ~32'h3, 1'b0, 32'h0));
    q.push_back(mk(1'b1, 12'h342, cause, 1'b0, 32'h0));
    q.push_back(mk(1'b1, 12'h343, tval, 1'b0, 32'h0));
    q.push_back(mk(1'b1, 12'h300, newst, 1'b0, 32'h0));
    q.push_back(mk(1'b0, 12'h000, 32'h0, 1'b1, vec));
  endfunction

  // Per-cycle comparison against the model, then model advance for the coming edge.
  always @(negedge clk) begin
    bit [31:0] mst;
    bit ext_ok, tim_ok, trig;
    ent_t e;
    if (q.size() == 0) begin
      mst    = (wb_we && wb_waddr == 12'h300) ? wb_wdata : mstatus;
      ext_ok = mstatus[3] && mie[11] && irq_ext;
      tim_ok = mstatus[3] && mie[7] && irq_timer;
      trig   = exc_valid || mret || ext_ok || tim_ok;
      chk("m_busy", {31'b0, busy}, 32'h0);
      chk("m_stall", {31'b0, wb_stall}, 32'h0);
      chk("m_rv", {31'b0, redirect_valid}, 32'h0);
      chk("m_rpc_idle", redirect_pc, 32'h0);
      chk("m_flush", {31'b0, flush}, {31'b0, (!rst && trig)});
      chk("m_we_pass", {31'b0, csr_we}, {31'b0, (!rst && wb_we)});
      if (!rst && wb_we) begin
        chk("m_addr_pass", {20'b0, csr_waddr}, {20'b0, wb_waddr});
        chk("m_data_pass", csr_wdata, wb_wdata);
      end
      if (!rst) begin
        if (exc_valid) push_trap(1'b0, {28'b0, exc_cause}, exc_pc, exc_tval, mst);
        else if (mret) begin
          q.push_back(mk(1'b1, 12'h300,
                         (mst & ~32'h0000_1888) | (mst[7] ? 32'h8 : 32'h0) | 32'h1880,
                         1'b0, 32'h0));
          q.push_back(mk(1'b0, 12'h000, 32'h0, 1'b1, mepc));
        end
        else if (ext_ok) push_trap(1'b1, 32'h8000000B, exc_pc, 32'h0, mst);
        else if (tim_ok) push_trap(1'b1, 32'h80000007, exc_pc, 32'h0, mst);
      end
    end else begin
      e = q.pop_front();
      chk("m_busy", {31'b0, busy}, 32'h1);
      chk("m_flush", {31'b0, flush}, 32'h0);
      chk("m_stall", {31'b0, wb_stall}, {31'b0, wb_we});
      chk("m_we", {31'b0, csr_we}, {31'b0, e.we});
      if (e.we) begin
        chk("m_addr", {20'b0, csr_waddr}, {20'b0, e.a});
        chk("m_data", csr_wdata, e.d);
      end
      chk("m_rv", {31'b0, redirect_valid}, {31'b0, e.rv});
      if (e.rv) chk("m_rpc", redirect_pc, e.rpc);
    end
    if (rst) q.delete();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    wb_we = 1'b0; wb_waddr = 12'h0; wb_wdata = 32'h0;
    exc_valid = 1'b0; exc_cause = 4'h0; exc_pc = 32'h0; exc_tval = 32'h0;
    mret = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0;
  endtask

  task automatic chk_wr(input string name, input logic [11:0] a, input logic [31:0] d);
    chk({name, "_we"}, {31'b0, csr_we}, 32'h1);
    chk({name, "_addr"}, {20'b0, csr_waddr}, {20'b0, a});
    chk({name, "_data"}, csr_wdata, d);
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    mstatus = 32'h0; mie = 32'h0; mtvec = 32'h0; mepc = 32'h0;
    wb_we = 1'b1; wb_waddr = 12'h340; exc_valid = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_we", {31'b0, csr_we}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_stall", {31'b0, wb_stall}, 32'h0);
    chk("rst_rv", {31'b0, redirect_valid}, 32'h0);
    chk("rst_rpc", redirect_pc, 32'h0);
    tick(); quiet(); rst = 1'b0;

    // Exception entry with literal expectations.
    mtvec = 32'h200; mstatus = 32'h8;
    tick();
    exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
    @(negedge clk); chk("exc_flush", {31'b0, flush}, 32'h1);
    tick(); quiet();
    @(negedge clk); chk_wr("exc_mepc", 12'h341, 32'h100);
    tick(); @(negedge clk); chk_wr("exc_mcause", 12'h342, 32'h2);
    tick(); @(negedge clk); chk_wr("exc_mtval", 12'h343, 32'hDEAD);
    tick(); @(negedge clk); chk_wr("exc_mstatus", 12'h300, 32'h1880);
    tick(); @(negedge clk);
    chk("exc_rv", {31'b0, redirect_valid}, 32'h1);
    chk("exc_rpc", redirect_pc, 32'h200);
    chk("exc_redir_we", {31'b0, csr_we}, 32'h0);
    tick(); @(negedge clk);
    chk("exc_done_busy", {31'b0, busy}, 32'h0);
    chk("exc_done_rpc", redirect_pc, 32'h0);

    // Vectored external interrupt, then the same with MIE clear.
    tick();
    mtvec = 32'h201; mstatus = 32'h8; mie = 32'h800; irq_ext = 1'b1;
    @(negedge clk); chk("irq_flush", {31'b0, flush}, 32'h1);
    tick(); irq_ext = 1'b0;
    tick(); @(negedge clk); chk_wr("irq_mcause", 12'h342, 32'h8000000B);
    tick(); tick(); tick(); @(negedge clk);
    chk("irq_rpc", redirect_pc, 32'h22C);
    tick(); mstatus = 32'h0; irq_ext = 1'b1;
    @(negedge clk); chk("irq_masked_flush", {31'b0, flush}, 32'h0);
    tick(); @(negedge clk); chk("irq_masked_busy", {31'b0, busy}, 32'h0);
    irq_ext = 1'b0;

    // mret.
    tick();
    mstatus = 32'h1880; mepc = 32'h104; mret = 1'b1;
    @(negedge clk); chk("mret_flush", {31'b0, flush}, 32'h1);
    tick(); mret = 1'b0;
    @(negedge clk); chk_wr("mret_mstatus", 12'h300, 32'h1888);
    tick(); @(negedge clk);
    chk("mret_rv", {31'b0, redirect_valid}, 32'h1);
    chk("mret_rpc", redirect_pc, 32'h104);

    // Stalled writeback request during a trap.
    tick(); mstatus = 32'h8; mtvec = 32'h200;
    tick(); exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'h300;
    tick(); quiet();
    tick(); wb_we = 1'b1; wb_waddr = 12'h340; wb_wdata = 32'h55;
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk); chk("stall_hold", {31'b0, wb_stall}, 32'h1);
      tick();
    end
    @(negedge clk);
    chk_wr("stall_issue", 12'h340, 32'h55);
    chk("stall_release", {31'b0, wb_stall}, 32'h0);
    tick(); quiet();

    // exc + mret together; later exception ignored while busy.
    tick(); exc_valid = 1'b1; mret = 1'b1; exc_cause = 4'd3; exc_pc = 32'h404;
    tick(); quiet();
    @(negedge clk); chk_wr("both_mepc", 12'h341, 32'h404);
    tick(); tick(); exc_valid = 1'b1; exc_cause = 4'd9;
    @(negedge clk); chk_wr("both_mtval", 12'h343, 32'h0);
    tick(); quiet(); tick(); tick();
    @(negedge clk); chk("both_idle", {31'b0, busy}, 32'h0);

    // Reset mid-trap, then immediate trigger after release.
    tick(); exc_valid = 1'b1; exc_cause = 4'd1; exc_pc = 32'h500;
    tick(); quiet();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; exc_valid = 1'b1; exc_cause = 4'd4; exc_pc = 32'h600;
    @(negedge clk);
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_we", {31'b0, csr_we}, 32'h0);
    chk("rst_mid_rv", {31'b0, redirect_valid}, 32'h0);
    chk("post_rst_flush", {31'b0, flush}, 32'h1);
    tick(); quiet();
    @(negedge clk); chk_wr("post_rst_mepc", 12'h341, 32'h600);
    repeat (6) tick();

    // Randomised traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst       = ($urandom_range(0, 199) == 0);
      exc_valid = ($urandom_range(0, 9) == 0);
      exc_cause = 4'($urandom);
      exc_pc    = $urandom;
      exc_tval  = $urandom;
      mret      = ($urandom_range(0, 11) == 0);
      irq_ext   = ($urandom_range(0, 5) == 0);
      irq_timer = ($urandom_range(0, 5) == 0);
      mstatus   = $urandom;
      mie       = $urandom;
      wb_we     = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: wb_waddr = 12'h300;
        1: wb_waddr = 12'h340;
        2: wb_waddr = 12'h341;
        default: wb_waddr = 12'($urandom);
      endcase
      wb_wdata = $urandom;
      if (q.size() == 0) begin
        mtvec = $urandom;
        mepc  = $urandom;
      end
    end
    tick(); quiet(); rst = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_trap_ctrl.md
CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

Interface
REQ-001 SHALL have parameter: XLEN, 32, data width of every CSR/PC bus.
REQ-002 SHALL have port: clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: wb_csr_we_i in 1, wb_csr_waddr_i in 12, wb_csr_wdata_i in XLEN  CSR write request from writeback.
REQ-005 SHALL have ports: exc_valid_i in 1, exc_cause_i in 4, exc_pc_i in XLEN, exc_tval_i in XLEN  synchronous exception report.
REQ-006 SHALL have ports: mret_i in 1 (mret retiring); irq_ext_i in 1, irq_timer_i in 1 (level interrupts).
REQ-007 SHALL have ports: mstatus_i, mie_i, mtvec_i, mepc_i  in  XLEN  current CSR contents from csrfile.
REQ-008 SHALL have ports: csr_we_o out 1, csr_waddr_o out 12, csr_wdata_o out XLEN  single csrfile write port.
REQ-009 SHALL have ports: wb_stall_o out 1 (writeback must hold its request), flush_o out 1, busy_o out 1.
REQ-010 SHALL have ports: redirect_valid_o out 1, redirect_pc_o out XLEN  fetch redirect.

Function
REQ-011 SHALL implement FSM states IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, MRET_ST, REDIRECT.
REQ-012 In IDLE, trigger priority SHALL be: exc_valid_i > mret_i > irq_ext_i > irq_timer_i.
REQ-013 Interrupt SHALL be eligible only if mstatus_i[3] (MIE)=1 and mie_i[11] (ext) or mie_i[7] (timer) set for that source.
REQ-014 On trap trigger at cycle T: flush_o=1 for cycle T; latch pc, cause, tval, mstatus; next state W_MEPC.
REQ-015 Latched mcause: exception {1'b0, 27'b0, exc_cause_i}; ext irq 32'h8000000B; timer irq 32'h80000007. Interrupt latched pc = exc_pc_i, tval = 0.
REQ-016 Trap sequence SHALL write one CSR per cycle: T+1 mepc(0x341)=pc&~3, T+2 mcause(0x342), T+3 mtval(0x343), T+4 mstatus(0x300), T+5 REDIRECT.
REQ-017 Trap mstatus value SHALL be latched value with bit7 (MPIE)=old bit3, bit3 (MIE)=0, bits[12:11] (MPP)=2'b11, others unchanged.
REQ-018 Trap redirect_pc_o SHALL be {mtvec_i[XLEN-1:2],2'b00} when mtvec_i[1:0]!=2'b01 or exception; base + 4*cause_code[3:0] when mode 01 and interrupt.
REQ-019 On mret trigger at T: flush_o=1 at T; T+1 MRET_ST writes mstatus with bit3=old bit7, bit7=1, bits[12:11]=2'b11; T+2 REDIRECT with redirect_pc_o=mepc_i.
REQ-020 REDIRECT SHALL assert redirect_valid_o for exactly one cycle, then return to IDLE; redirect_pc_o is don't-care when redirect_valid_o=0 but SHALL read 0 in IDLE.
REQ-021 busy_o SHALL be 1 in every state except IDLE.
REQ-022 Arbitration: in IDLE, csr_*_o SHALL pass wb_csr_*_i combinationally; in non-IDLE, controller owns the port.
REQ-023 wb_stall_o SHALL equal wb_csr_we_i & busy_o; the stalled request SHALL issue on the first IDLE cycle unaltered.
REQ-024 Trigger-cycle wb write to 0x300 SHALL be bypassed into the latched mstatus (wb_csr_wdata_i replaces mstatus_i).
REQ-025 exc_valid_i, mret_i and interrupts SHALL be ignored while busy_o=1; no queueing.
REQ-026 CSR write in REDIRECT and MRET_ST-only-once: csr_we_o SHALL be 0 in REDIRECT unless passing nothing (controller-owned, idle write).

Reset
REQ-027 While rst_i=1 at a clock edge, state SHALL return to IDLE from any state, aborting any sequence.
REQ-028 Reset values: csr_we_o=0, flush_o=0, busy_o=0, redirect_valid_o=0, redirect_pc_o=0, wb_stall_o=0, latches=0.
REQ-029 First cycle after reset release SHALL accept triggers normally.

Verification
REQ-030 exc_valid_i=1, cause=2, pc=0x100, tval=0xDEAD, mtvec=0x200, mstatus=0x8 -> writes 0x341=0x100, 0x342=2, 0x343=0xDEAD, 0x300=0x1880; redirect 0x200 at T+5.
REQ-031 mtvec=0x201, mstatus=0x8, mie=0x800, irq_ext_i=1 -> mcause 0x8000000B; redirect 0x22C; same with mstatus=0 -> no trigger.
REQ-032 mret_i=1, mstatus=0x1880, mepc=0x104 -> 0x300 written 0x1888 at T+1; redirect 0x104 at T+2.
REQ-033 wb write 0x340=0x55 at T+2 of trap -> wb_stall_o=1 through T+5; write issues at T+6 with data 0x55.
REQ-034 exc_valid_i and mret_i both 1 in IDLE -> exception sequence only; exc_valid_i at T+3 ignored.
REQ-035 rst_i=1 at T+2 of trap -> IDLE, busy_o=0 next cycle, no mtval/mstatus writes, no redirect.
